mmss_time_counter: RTL and testbench
====================================

Name: mmss_time_counter

Overview:
- Time-of-day source for the lab clock datapath. Holds a prescaler that divides the board clock to a 1 Hz tick, and a four-digit BCD MM:SS counter.
- Provides a SET mode for adjusting minutes and seconds.
- Outputs each digit's next value together with a one-cycle per-digit load strobe. Downstream clock-enabled display holding registers consume these directly, as d and ce.

Parameters:
- CLK_DIV, 12000000, board clock cycles per 1 Hz tick; legal values are ≥ 2.
- PRE_W, 24, prescaler counter width; must satisfy 2^PRE_W ≥ CLK_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock clk
- run  in  1  level; 1 = count in COUNT mode, 0 = pause
- mode_btn  in  1  one-cycle pulse; toggles COUNT/SET
- set_sec  in  1  one-cycle pulse; seconds +1 (SET mode only)
- set_min  in  1  one-cycle pulse; minutes +1 (SET mode only)
- clr  in  1  one-cycle pulse; zero time and prescaler
- sec_lo  out  4  BCD seconds units, 0-9
- sec_hi  out  4  BCD seconds tens, 0-5
- min_lo  out  4  BCD minutes units, 0-9
- min_hi  out  4  BCD minutes tens, 0-5
- tick  out  1  registered 1 Hz strobe
- dig_ce  out  4  per-digit load strobe, in order {min_hi, min_lo, sec_hi, sec_lo}
- rollover  out  1  pulse on 59:59 -> 00:00 wrap
- set_mode  out  1  1 while FSM is in SET

Behaviour:
- Reset (rst=1 at posedge): all digits 0, prescaler 0, FSM = COUNT. tick, dig_ce, rollover and set_mode are all 0. rst overrides every other input.
- FSM states and transitions:
  - COUNT -(mode_btn)-> SET.
  - SET -(mode_btn)-> COUNT.
  - Entering SET clears the prescaler to 0.
- Prescaler:
  - Increments only when FSM = COUNT and run = 1.
  - When the value is CLK_DIV-1, it wraps to 0 and internal tick_req = 1.
  - Otherwise it holds.
- The tick output is tick_req registered, so it is high for 1 cycle once every CLK_DIV enabled cycles.
- Time update on tick_req (COUNT only):
  - sec_lo +1; 9 -> 0 with carry.
  - sec_hi 5 -> 0 with carry into minutes.
  - min_lo / min_hi likewise.
  - 59:59 -> 00:00 also asserts rollover.
- SET mode:
  - set_sec: seconds (sec_hi:sec_lo) +1 mod 60; no carry into minutes.
  - set_min: minutes +1 mod 60; no rollover.
  - Both pulses in the same cycle: both apply.
- set_sec and set_min are ignored in COUNT. mode_btn, set_sec and set_min are treated as single-cycle pulses.
- Priority, highest first: rst > clr > mode_btn > set_* > tick_req.
  - mode_btn in the same cycle as tick_req: the mode change occurs and the tick is dropped.
- clr:
  - Digits 00:00 and prescaler 0; FSM is unchanged.
  - A coincident tick_req is discarded.
  - dig_ce = 4'b1111 in the next cycle.
- Latency: digit registers, dig_ce, rollover and tick all update at the same posedge, one cycle after the causing event or prescaler wrap.
  - dig_ce[i] = 1 for exactly the one cycle in which the new value of digit i is first presented on its output.
  - dig_ce[i] covers only digits actually written by that event; for example 00:09 -> 00:10 gives 4'b0011.
- Digit outputs never take values outside their legal range.

Decomposition:
- Package mmss_pkg holds:
  - typedef enum {COUNT, SET} mode_t
  - BCD_MAX_LO = 9, BCD_MAX_HI = 5
  - DIG_SEC_LO..DIG_MIN_HI index constants for dig_ce
- Sub-module bcd_mod_cnt #(MAX): one BCD digit with inc / clr inputs, registered value output, carry = inc && (value == MAX). Instantiate it four times and chain the carries. set_* forces inc at the sec_lo / min_lo digit with the carry out of the hi digit suppressed.
- Prescaler and FSM live in the top level.

Test Plan (CLK_DIV=4, PRE_W=3):
- rst for 2 cycles then run=1 -> outputs all 0, set_mode=0; first tick 4 cycles after rst falls, then every 4 cycles; sec_lo=1 after the first tick.
- Count to 00:09, one more tick -> 00:10, dig_ce=4'b0011 for 1 cycle, rollover=0.
- clr, then 59 set_min and 59 set_sec pulses in SET, mode_btn back to COUNT, 1 tick -> 00:00, dig_ce=4'b1111, rollover=1 for exactly 1 cycle.
- SET mode at 12:59, set_sec -> 12:00 (min unchanged), dig_ce=4'b0011; set_min at 59:00 -> 00:00, rollover=0; no tick while in SET for 20 cycles.
- run=0 for 10 cycles mid-prescale (value 2) -> no tick, prescaler holds 2; run=1 -> tick after 2 more cycles.
- clr coincident with tick_req at 03:07 -> 00:00, dig_ce=4'b1111, no increment; rst asserted mid-count at 45:30 -> 00:00 next cycle, dig_ce=0, FSM=COUNT.

Source files
------------

// File: rtl/mmss_pkg.sv
// Shared types and constants for the MM:SS time counter.
package mmss_pkg;

  typedef enum logic {COUNT = 1'b0, SET = 1'b1} mode_t;

  localparam logic [3:0] BCD_MAX_LO = 4'd9;
  localparam logic [3:0] BCD_MAX_HI = 4'd5;

  localparam int DIG_SEC_LO = 0;
  localparam int DIG_SEC_HI = 1;
  localparam int DIG_MIN_LO = 2;
  localparam int DIG_MIN_HI = 3;

endpackage

// File: rtl/bcd_mod_cnt.sv
// One BCD digit counting 0..MAX; carry flags the wrap in the cycle inc is applied.
module bcd_mod_cnt #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] value,
  output logic       carry
);

  assign carry = inc && (value == MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= carry ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/mmss_time_counter.sv
// MM:SS time-of-day source: 1 Hz prescaler, COUNT/SET mode FSM and a chained BCD digit counter.
module mmss_time_counter
  import mmss_pkg::*;
#(
  parameter int CLK_DIV = 12000000,
  parameter int PRE_W   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_btn,
  input  logic       set_sec,
  input  logic       set_min,
  input  logic       clr,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       tick,
  output logic [3:0] dig_ce,
  output logic       rollover,
  output logic       set_mode
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  mode_t            mode;
  logic [PRE_W-1:0] pre;

  logic tick_req, tick_evt, mode_evt, set_sec_evt, set_min_evt;
  logic inc_sl, inc_sh, inc_ml, inc_mh;
  logic c_sl, c_sh, c_ml, c_mh;
  logic [3:0] ce_next;

  // Priority: clr > mode_btn > set_* > tick_req.
  assign tick_req    = (mode == COUNT) && run && (pre == PRE_LAST);
  assign mode_evt    = mode_btn && !clr;
  assign tick_evt    = tick_req && !clr && !mode_evt;
  assign set_sec_evt = (mode == SET) && set_sec && !clr && !mode_evt;
  assign set_min_evt = (mode == SET) && set_min && !clr && !mode_evt;

  // Set pulses enter at the lo digit; the hi-digit carry never crosses seconds->minutes.
  assign inc_sl = tick_evt || set_sec_evt;
  assign inc_sh = c_sl;
  assign inc_ml = (tick_evt && c_sh) || set_min_evt;
  assign inc_mh = c_ml;

  always_comb begin
    ce_next             = '0;
    ce_next[DIG_SEC_LO] = inc_sl;
    ce_next[DIG_SEC_HI] = inc_sh;
    ce_next[DIG_MIN_LO] = inc_ml;
    ce_next[DIG_MIN_HI] = inc_mh;
  end

  bcd_mod_cnt #(.MAX(BCD_MAX_LO)) u_sec_lo (
    .clk(clk), .rst(rst), .inc(inc_sl), .clr(clr), .value(sec_lo), .carry(c_sl)
  );
  bcd_mod_cnt #(.MAX(BCD_MAX_HI)) u_sec_hi (
    .clk(clk), .rst(rst), .inc(inc_sh), .clr(clr), .value(sec_hi), .carry(c_sh)
  );
  bcd_mod_cnt #(.MAX(BCD_MAX_LO)) u_min_lo (
    .clk(clk), .rst(rst), .inc(inc_ml), .clr(clr), .value(min_lo), .carry(c_ml)
  );
  bcd_mod_cnt #(.MAX(BCD_MAX_HI)) u_min_hi (
    .clk(clk), .rst(rst), .inc(inc_mh), .clr(clr), .value(min_hi), .carry(c_mh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= COUNT;
      pre      <= '0;
      tick     <= 1'b0;
      dig_ce   <= '0;
      rollover <= 1'b0;
    end else begin
      tick     <= tick_evt;
      rollover <= tick_evt && c_mh;
      dig_ce   <= clr ? 4'b1111 : ce_next;
      if (mode_evt) begin
        mode <= (mode == COUNT) ? SET : COUNT;
      end
      // Entering SET restarts the second so leaving SET gives a full period.
      if (clr || (mode_evt && mode == COUNT)) begin
        pre <= '0;
      end else if (mode == COUNT && run) begin
        pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
      end
    end
  end

  assign set_mode = (mode == SET);

endmodule

// File: tb/tb_mmss_time_counter.sv
// Bench for mmss_time_counter: per-cycle scoreboard against a behavioural time model plus directed checks.
module tb_mmss_time_counter;

  localparam int CLK_DIV = 4;
  localparam int PRE_W   = 3;

  logic       clk = 1'b0;
  logic       rst, run, mode_btn, set_sec, set_min, clr;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, dig_ce;
  logic       tick, rollover, set_mode;

  mmss_time_counter #(.CLK_DIV(CLK_DIV), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .run(run), .mode_btn(mode_btn), .set_sec(set_sec),
    .set_min(set_min), .clr(clr), .sec_lo(sec_lo), .sec_hi(sec_hi),
    .min_lo(min_lo), .min_hi(min_hi), .tick(tick), .dig_ce(dig_ce),
    .rollover(rollover), .set_mode(set_mode)
  );

  always #5 clk = ~clk;

  wire [15:0] digs = {min_hi, min_lo, sec_hi, sec_lo};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] digs;
    logic [3:0]  ce;
    logic        roll;
    logic        tick;
    logic        sm;
  } exp_t;

  exp_t q[$];

  // Behavioural model in plain minutes/seconds arithmetic
  int m = 0, s = 0, pre = 0, md = 0;

  always begin
    exp_t e;
    exp_t g;
    logic [3:0] ce;
    logic roll, tk, tr;
    @(posedge clk);
    ce = '0; roll = 1'b0; tk = 1'b0;
    if (rst) begin
      m = 0; s = 0; pre = 0; md = 0;
    end else begin
      tr = (md == 0) && run && (pre == CLK_DIV - 1);
      if (clr) begin
        m = 0; s = 0; pre = 0; ce = 4'b1111;
      end else if (mode_btn) begin
        if (md == 0) pre = 0;
        md = 1 - md;
      end else begin
        if (md == 0 && run) pre = (pre == CLK_DIV - 1) ? 0 : pre + 1;
        if (md == 1) begin
          if (set_sec) begin
            ce |= (s % 10 == 9) ? 4'b0011 : 4'b0001;
            s = (s + 1) % 60;
          end
          if (set_min) begin
            ce |= (m % 10 == 9) ? 4'b1100 : 4'b0100;
            m = (m + 1) % 60;
          end
        end else if (tr) begin
          tk = 1'b1;
          ce = 4'b0001;
          if (s % 10 == 9) ce[1] = 1'b1;
          if (s == 59) ce[2] = 1'b1;
          if (s == 59 && m % 10 == 9) ce[3] = 1'b1;
          roll = (s == 59 && m == 59);
          s = s + 1;
          if (s == 60) begin
            s = 0;
            m = (m + 1) % 60;
          end
        end
      end
    end
    e.digs = 16'((m / 10) << 12 | (m % 10) << 8 | (s / 10) << 4 | (s % 10));
    e.ce = ce; e.roll = roll; e.tick = tk; e.sm = (md == 1);
    q.push_back(e);
    #1;
    g = q.pop_front();
    chk("sb_digits", {16'h0, digs}, {16'h0, g.digs});
    chk("sb_dig_ce", {28'h0, dig_ce}, {28'h0, g.ce});
    chk("sb_rollover", {31'h0, rollover}, {31'h0, g.roll});
    chk("sb_tick", {31'h0, tick}, {31'h0, g.tick});
    chk("sb_set_mode", {31'h0, set_mode}, {31'h0, g.sm});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic p_mode();
    mode_btn = 1'b1; @(negedge clk); mode_btn = 1'b0;
  endtask
  task automatic p_sec();
    set_sec = 1'b1; @(negedge clk); set_sec = 1'b0;
  endtask
  task automatic p_min();
    set_min = 1'b1; @(negedge clk); set_min = 1'b0;
  endtask
  task automatic p_clr();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
  endtask

  task automatic wait_tick(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 20);
    if (!tick) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic count_ticks(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (tick) c++;
    end
  endtask

  task automatic load_time(input int mm, input int ss);
    p_clr();
    p_mode();
    repeat (mm) p_min();
    repeat (ss) p_sec();
    p_mode();
  endtask

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; mode_btn = 1'b0; set_sec = 1'b0; set_min = 1'b0; clr = 1'b0;
    cyc(2);
    chk("rst_digits", {16'h0, digs}, 32'h0);
    chk("rst_flags", {28'h0, tick, rollover, set_mode, |dig_ce}, 32'h0);
    rst = 1'b0; run = 1'b1;

    wait_tick("first", n);
    chk("first_tick_delay", n, 4);
    chk("first_tick_sec", {16'h0, digs}, 32'h0001);
    wait_tick("second", n);
    chk("tick_period", n, 4);
    repeat (7) wait_tick("to9", n);
    chk("at_0009", {16'h0, digs}, 32'h0009);
    wait_tick("to10", n);
    chk("at_0010", {16'h0, digs}, 32'h0010);
    chk("ce_0010", {28'h0, dig_ce}, 32'h3);
    chk("roll_0010", {31'h0, rollover}, 32'h0);
    cyc(1);
    chk("ce_0010_gone", {28'h0, dig_ce}, 32'h0);

    p_clr();
    p_mode();
    chk("in_set", {31'h0, set_mode}, 32'h1);
    repeat (59) p_min();
    repeat (59) p_sec();
    chk("at_5959", {16'h0, digs}, 32'h5959);
    p_mode();
    wait_tick("wrap", n);
    chk("wrap_digits", {16'h0, digs}, 32'h0000);
    chk("wrap_ce", {28'h0, dig_ce}, 32'hf);
    chk("wrap_roll", {31'h0, rollover}, 32'h1);
    cyc(1);
    chk("wrap_roll_once", {31'h0, rollover}, 32'h0);

    p_clr();
    p_mode();
    repeat (12) p_min();
    repeat (59) p_sec();
    chk("at_1259", {16'h0, digs}, 32'h1259);
    p_sec();
    chk("set_sec_wrap", {16'h0, digs}, 32'h1200);
    chk("set_sec_ce", {28'h0, dig_ce}, 32'h3);
    repeat (47) p_min();
    chk("at_5900", {16'h0, digs}, 32'h5900);
    p_min();
    chk("set_min_wrap", {16'h0, digs}, 32'h0000);
    chk("set_min_roll", {31'h0, rollover}, 32'h0);
    chk("set_min_ce", {28'h0, dig_ce}, 32'hc);
    set_sec = 1'b1; set_min = 1'b1; @(negedge clk); set_sec = 1'b0; set_min = 1'b0;
    chk("both_set", {16'h0, digs}, 32'h0101);
    count_ticks(20, n);
    chk("no_tick_in_set", n, 0);
    p_mode();

    cyc(2);
    run = 1'b0;
    count_ticks(10, n);
    chk("paused_no_tick", n, 0);
    run = 1'b1;
    wait_tick("resume", n);
    chk("resume_delay", n, 2);

    load_time(3, 7);
    cyc(3);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("clr_tick_digits", {16'h0, digs}, 32'h0000);
    chk("clr_tick_ce", {28'h0, dig_ce}, 32'hf);
    chk("clr_tick_tick", {31'h0, tick}, 32'h0);

    load_time(45, 30);
    cyc(2);
    rst = 1'b1; @(negedge clk);
    chk("mid_rst_digits", {16'h0, digs}, 32'h0000);
    chk("mid_rst_ce", {28'h0, dig_ce}, 32'h0);
    chk("mid_rst_mode", {31'h0, set_mode}, 32'h0);
    rst = 1'b0;
    cyc(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
